// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the multicycle LEGv8 main controller:
// FSM states, opcode patterns, ALU select encodings and instruction classes.
package legv8_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC,
        ST_ALUWB,
        ST_BRANCH
    } state_t;

    // Opcode patterns on IR[31:21]; CBZ carries don't-care low bits for casez
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    // ALU operation select
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_PASS_B = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_t;

    // ALU operand B select
    typedef enum logic [1:0] {
        SRCB_REG      = 2'b00,
        SRCB_FOUR     = 2'b01,
        SRCB_SEXT     = 2'b10,
        SRCB_SEXT_SH2 = 2'b11
    } alu_src_b_t;

    // Instruction classes the FSM sequences on
    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_LOAD,
        CL_STORE,
        CL_CBZ,
        CL_ILLEGAL
    } instr_class_t;

    // Classes that read Rt through the second register port
    function automatic logic reads_rt(instr_class_t c);
        return (c == CL_STORE) || (c == CL_CBZ);
    endfunction

endpackage

// File: rtl/legv8_op_class.sv
// Opcode classifier: maps IR[31:21] onto the instruction class consumed
// by the main control FSM. Purely combinational.
module legv8_op_class
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] op_i,
    output logic [2:0]  class_o
);

    instr_class_t cls;

    // Match the opcode against the supported patterns
    always_comb begin
        cls = CL_ILLEGAL;
        casez (op_i)
            OP_LDUR: cls = CL_LOAD;
            OP_STUR: cls = CL_STORE;
            OP_CBZ:  cls = CL_CBZ;
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_ORR:  cls = CL_RTYPE;
            default: cls = CL_ILLEGAL;
        endcase
    end

    assign class_o = cls;

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath. Sequences
// fetch/decode/execute/memory/writeback, drives datapath selects and
// enables, handshakes with the single memory port and counts retirements.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg2loc,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instret
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  instret_q;
    logic                  retire;
    logic [2:0]            class_raw;
    instr_class_t          op_cls;
    alu_op_t               alu_op_e;
    alu_src_b_t            alu_src_b_e;

    legv8_op_class u_op_class (
        .op_i    (op),
        .class_o (class_raw)
    );

    assign op_cls = instr_class_t'(class_raw);

    // Next state, retirement strobe and per-state datapath controls.
    // Everything is forced low while reset is high so an access in flight
    // is dropped in the same cycle reset asserts.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b_e = SRCB_REG;
        alu_op_e    = ALU_ADD;
        reg2loc     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_op  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b_e = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b_e = SRCB_SEXT_SH2;
                reg2loc     = reads_rt(op_cls);
                unique case (op_cls)
                    CL_LOAD, CL_STORE: state_d = ST_MEMADR;
                    CL_CBZ:            state_d = ST_BRANCH;
                    CL_RTYPE:          state_d = ST_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b_e = SRCB_SEXT;
                if (op_cls == CL_LOAD) begin
                    state_d = ST_MEMRD;
                end else if (op_cls == CL_STORE) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                reg2loc   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op_e  = ALU_FUNCT;
                state_d   = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                reg2loc   = 1'b1;
                alu_src_a = 1'b1;
                alu_op_e  = ALU_PASS_B;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (reset) begin
            state_d     = ST_FETCH;
            retire      = 1'b0;
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b_e = SRCB_REG;
            alu_op_e    = ALU_ADD;
            reg2loc     = 1'b0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign alu_src_b = alu_src_b_e;
    assign alu_op    = alu_op_e;
    assign instret   = instret_q;

    // State register and retired-instruction counter (wraps naturally)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for the multicycle LEGv8 controller. The driver walks each
// instruction through its phases as described by the ISA sequencing rules,
// pushing the expected control vector and retire count for every cycle; an
// independent monitor pops and compares on the falling edge.
module tb_legv8_multicycle_ctrl;

    localparam logic [10:0] I_LDUR = 11'b11111000010;
    localparam logic [10:0] I_STUR = 11'b11111000000;
    localparam logic [10:0] I_ADD  = 11'b10001011000;
    localparam logic [10:0] I_SUB  = 11'b11001011000;
    localparam logic [10:0] I_AND  = 11'b10001010000;
    localparam logic [10:0] I_ORR  = 11'b10101010000;
    localparam logic [10:0] I_CBZ  = 11'b10110100000;
    localparam logic [10:0] I_BAD  = 11'b11111111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] op = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, iord, ir_write, pc_write, pc_src;
    logic        alu_src_a, reg2loc, reg_write, mem_to_reg, illegal_op;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] instret;

    legv8_multicycle_ctrl #(.CNT_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg2loc    (reg2loc),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] model_cnt = '0;
    logic [10:0] nxt_op = '0;

    // Control vector layout: mem_req mem_write iord ir_write pc_write pc_src
    // alu_src_a alu_src_b[1:0] alu_op[1:0] reg2loc reg_write mem_to_reg illegal_op
    function automatic logic [14:0] mk(input logic mreq, input logic mwr, input logic ad,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] ao,
                                       input logic r2l, input logic rw, input logic m2r,
                                       input logic ill);
        return {mreq, mwr, ad, irw, pcw, pcs, sa, sb, ao, r2l, rw, m2r, ill};
    endfunction

    // Reference decode: 0 R-type, 1 load, 2 store, 3 cbz, 4 illegal
    function automatic int ref_class(input logic [10:0] o);
        logic [7:0] hi;
        hi = o[10:3];
        if (o == I_LDUR) return 1;
        if (o == I_STUR) return 2;
        if (hi == 8'b10110100) return 3;
        if (o == I_ADD || o == I_SUB || o == I_AND || o == I_ORR) return 0;
        return 4;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle out of reset with the expected controls for it
    task automatic step(input logic rdy, input logic z, input logic [14:0] ctl, input logic ret);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        op        = nxt_op;
        mem_ready = rdy;
        zero      = z;
        e.ctl     = ctl;
        e.cnt     = model_cnt;
        exp_q.push_back(e);
        mon_en    = 1'b1;
        if (ret) model_cnt = model_cnt + 32'd1;
    endtask

    // One clock cycle with reset asserted: everything low, counter cleared
    task automatic step_rst();
        exp_t e;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = rbit();
        zero      = rbit();
        model_cnt = '0;
        e.ctl     = '0;
        e.cnt     = '0;
        exp_q.push_back(e);
        mon_en    = 1'b1;
    endtask

    // Walk one instruction: wf/wm are memory wait cycles for fetch/data access;
    // abort stops a store after one unaccepted write cycle
    task automatic run_instr(input logic [10:0] o, input logic z, input int unsigned wf,
                             input int unsigned wm, input logic abort);
        int  c;
        logic last;
        c = ref_class(o);
        nxt_op = o;
        for (int unsigned i = 0; i <= wf; i++) begin
            last = (i == wf);
            step(last, rbit(), mk(1, 0, 0, last, last, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0), 0);
        end
        step(rbit(), rbit(),
             mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, (c == 2 || c == 3), 0, 0, (c == 4)), 0);
        case (c)
            0: begin
                step(rbit(), rbit(), mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0), 0);
                step(rbit(), rbit(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0), 1);
            end
            1: begin
                step(rbit(), rbit(), mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0), 0);
                for (int unsigned i = 0; i <= wm; i++) begin
                    step(i == wm, rbit(), mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0), 0);
                end
                step(rbit(), rbit(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0), 1);
            end
            2: begin
                step(rbit(), rbit(), mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0), 0);
                if (abort) begin
                    step(0, rbit(), mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0), 0);
                end else begin
                    for (int unsigned i = 0; i <= wm; i++) begin
                        last = (i == wm);
                        step(last, rbit(), mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0), last);
                    end
                end
            end
            3: begin
                step(rbit(), z, mk(0, 0, 0, 0, z, 1, 1, 2'b00, 2'b01, 1, 0, 0, 0), 1);
            end
            default: ;
        endcase
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    initial begin
        exp_t        e;
        logic [14:0] got;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                got = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                       alu_src_b, alu_op, reg2loc, reg_write, mem_to_reg, illegal_op};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_underflow t=%0t got ctl=%b instret=%0d", $time, got, instret);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.ctl || instret !== e.cnt) begin
                        n_errors++;
                        $display("FAIL cycle_ctl t=%0t got ctl=%b instret=%0d expected ctl=%b instret=%0d",
                                 $time, got, instret, e.ctl, e.cnt);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized instruction stream
    initial begin
        int unsigned k;
        logic [10:0] o;
        int unsigned wf, wm;

        repeat (3) step_rst();

        run_instr(I_ADD, 1'b0, 0, 0, 1'b0);
        run_instr(I_LDUR, 1'b1, 0, 2, 1'b0);
        run_instr(I_CBZ, 1'b1, 0, 0, 1'b0);
        run_instr(I_CBZ | 11'b101, 1'b0, 0, 0, 1'b0);
        run_instr(I_BAD, 1'b0, 0, 0, 1'b0);
        run_instr(I_STUR, 1'b0, 1, 0, 1'b0);
        run_instr(I_SUB, 1'b0, 2, 0, 1'b0);
        run_instr(I_STUR, 1'b0, 0, 0, 1'b1);
        repeat (2) step_rst();
        run_instr(I_ORR, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 8);
            case (k)
                0: o = I_ADD;
                1: o = I_SUB;
                2: o = I_AND;
                3: o = I_ORR;
                4: o = I_LDUR;
                5: o = I_STUR;
                6: o = I_CBZ | 11'($urandom_range(0, 7));
                7: o = 11'($urandom);
                default: o = I_BAD;
            endcase
            wf = (rbit() ? 0 : $urandom_range(0, 3));
            wm = (rbit() ? 0 : $urandom_range(0, 3));
            run_instr(o, rbit(), wf, wm, 1'b0);
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
